// File: rtl/inc_engine.sv
// Receive FIFO feeding a hold/operate/send engine with a local switch-send bypass.
// Optional feature: define INC_ENGINE_DROP_CNT_EN to add the saturating drop_cnt output.
module inc_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int DELAY_COUNT = 20,
    parameter int STEP        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_write_en_in,
    input  logic                  button,
    input  logic [DATA_WIDTH-1:0] sw_array_data,
    input  logic [1:0]            mode,
    input  logic                  m_tx_done,
    output logic [DATA_WIDTH-1:0] m_data_out,
    output logic                  m_tx_req,
    output logic [DATA_WIDTH-1:0] disp_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
`ifdef INC_ENGINE_DROP_CNT_EN
    output logic [7:0]            drop_cnt,
`endif
    output logic                  ovf_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]         FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]         HOLD_LAST = 16'(DELAY_COUNT);
    localparam logic [DATA_WIDTH:0] STEP_V    = (DATA_WIDTH+1)'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        SEND = 2'b10
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    state_t                state_q;
    logic [15:0]           cnt_q;
    logic [DATA_WIDTH-1:0] work_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_req_q;
    logic                  ovf_q;
    logic [7:0]            drop_cnt_q;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [DATA_WIDTH-1:0] result_d;

    function automatic logic [DATA_WIDTH-1:0] apply_op(input logic [1:0] m,
                                                       input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, v} + STEP_V;
        case (m)
            2'b00:   apply_op = sum[DATA_WIDTH-1:0];
            2'b01:   apply_op = v - STEP_V[DATA_WIDTH-1:0];
            2'b10:   apply_op = v;
            2'b11:   apply_op = sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
            default: apply_op = v;
        endcase
    endfunction

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign pop_s      = (state_q == IDLE) && !fifo_empty;
    // A full FIFO still accepts when the engine frees a slot on the same edge.
    assign push_s     = s_write_en_in && (!fifo_full || pop_s);
    assign drop_s     = s_write_en_in && fifo_full && !pop_s;
    assign result_d   = apply_op(mode, work_q);

    assign m_data_out = m_data_q;
    assign m_tx_req   = m_req_q;
    assign disp_data  = work_q;
    assign ovf_err    = ovf_q;
`ifdef INC_ENGINE_DROP_CNT_EN
    assign drop_cnt   = drop_cnt_q;
`endif

    // FIFO storage write; contents need no reset since count_q gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else if (drop_s) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    // Engine FSM: IDLE picks work, HOLD displays then operates, SEND handshakes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            work_q   <= '0;
            m_data_q <= '0;
            m_req_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        work_q  <= mem_q[rd_ptr_q];
                        cnt_q   <= 16'd0;
                        state_q <= HOLD;
                    // An arriving strobe outranks the button so slave data goes first.
                    end else if (button && !s_write_en_in) begin
                        work_q   <= sw_array_data;
                        m_data_q <= sw_array_data;
                        m_req_q  <= 1'b1;
                        state_q  <= SEND;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        work_q   <= result_d;
                        m_data_q <= result_d;
                        m_req_q  <= 1'b1;
                        state_q  <= SEND;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                SEND: begin
                    if (m_tx_done) begin
                        m_req_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    m_req_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inc_engine.sv
// Directed self-checking bench for inc_engine (DW=8, FIFO_DEPTH=4, DELAY_COUNT=3, STEP=1).
module tb_inc_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_write_en_in = 1'b0;
    logic       button = 1'b0;
    logic [7:0] sw_array_data = 8'h00;
    logic [1:0] mode = 2'b00;
    logic       m_tx_done = 1'b0;
    logic [7:0] m_data_out;
    logic       m_tx_req;
    logic [7:0] disp_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic       ovf_err;
`ifdef INC_ENGINE_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int total = 0;
    int bad = 0;

    inc_engine #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DELAY_COUNT(3), .STEP(1)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_write_en_in(s_write_en_in),
        .button(button), .sw_array_data(sw_array_data), .mode(mode), .m_tx_done(m_tx_done),
        .m_data_out(m_data_out), .m_tx_req(m_tx_req), .disp_data(disp_data),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
`ifdef INC_ENGINE_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        s_data = d;
        s_write_en_in = 1'b1;
        tick();
        s_write_en_in = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        for (int k = 0; k < 40; k++) begin
            if (m_tx_req === 1'b1) break;
            tick();
        end
        ok = (m_tx_req === 1'b1);
    endtask

    task automatic done_pulse();
        m_tx_done = 1'b1;
        tick();
        m_tx_done = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (m_tx_req !== 1'b0 || m_data_out !== 8'h00 || disp_data !== 8'h00) begin
            bad++; $display("FAIL reset_out: req=%b data=%h disp=%h want 0/00/00", m_tx_req, m_data_out, disp_data);
        end
        total++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || ovf_err !== 1'b0) begin
            bad++; $display("FAIL reset_flags: empty=%b full=%b ovf=%b want 1/0/0", fifo_empty, fifo_full, ovf_err);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        mode = 2'b00;
        strobe(8'h41);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (disp_data !== 8'h41 || m_tx_req !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d: disp=%h req=%b want 41/0", i, disp_data, m_tx_req);
            end
        end
        tick();
        total++;
        if (m_tx_req !== 1'b1 || m_data_out !== 8'h42 || disp_data !== 8'h42) begin
            bad++; $display("FAIL send_entry: req=%b data=%h disp=%h want 1/42/42", m_tx_req, m_data_out, disp_data);
        end
        tick();
        tick();
        total++;
        if (m_tx_req !== 1'b1 || m_data_out !== 8'h42) begin
            bad++; $display("FAIL send_stable: req=%b data=%h want 1/42", m_tx_req, m_data_out);
        end
        done_pulse();
        total++;
        if (m_tx_req !== 1'b0 || disp_data !== 8'h42) begin
            bad++; $display("FAIL send_done: req=%b disp=%h want 0/42", m_tx_req, disp_data);
        end
        tick();
        total++;
        if (m_tx_req !== 1'b0) begin
            bad++; $display("FAIL idle_after_done: req=%b want 0", m_tx_req);
        end
    endtask

    task automatic test_modes();
        logic [1:0] md  [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
        logic [7:0] vin [6] = '{8'hFF, 8'h00, 8'hFF, 8'h5A, 8'hFE, 8'h10};
        logic [7:0] vexp[6] = '{8'h00, 8'hFF, 8'hFF, 8'h5A, 8'hFF, 8'h0F};
        bit ok;
        for (int i = 0; i < 6; i++) begin
            mode = md[i];
            strobe(vin[i]);
            wait_req(ok);
            total++;
            if (!ok || m_data_out !== vexp[i]) begin
                bad++; $display("FAIL mode%0d_case%0d: req=%b data=%h want 1/%h", md[i], i, m_tx_req, m_data_out, vexp[i]);
            end
            done_pulse();
        end
        // mode changes early in HOLD; only the value on the last HOLD cycle counts
        mode = 2'b10;
        strobe(8'h20);
        tick();
        mode = 2'b00;
        wait_req(ok);
        total++;
        if (!ok || m_data_out !== 8'h21) begin
            bad++; $display("FAIL mode_sample: req=%b data=%h want 1/21", m_tx_req, m_data_out);
        end
        done_pulse();
    endtask

    task automatic test_button();
        bit ok;
        button = 1'b1;
        sw_array_data = 8'h3C;
        tick();
        total++;
        if (m_tx_req !== 1'b1 || m_data_out !== 8'h3C || disp_data !== 8'h3C) begin
            bad++; $display("FAIL button_send: req=%b data=%h disp=%h want 1/3c/3c", m_tx_req, m_data_out, disp_data);
        end
        button = 1'b0;
        done_pulse();
        mode = 2'b00;
        button = 1'b1;
        strobe(8'h10);
        wait_req(ok);
        total++;
        if (!ok || m_data_out !== 8'h11) begin
            bad++; $display("FAIL strobe_priority: req=%b data=%h want 1/11", m_tx_req, m_data_out);
        end
        done_pulse();
        tick();
        total++;
        if (m_tx_req !== 1'b1 || m_data_out !== 8'h3C) begin
            bad++; $display("FAIL button_after: req=%b data=%h want 1/3c", m_tx_req, m_data_out);
        end
        button = 1'b0;
        done_pulse();
    endtask

    task automatic test_overflow();
        logic [7:0] drain[5] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h08};
        bit ok;
        mode = 2'b00;
        for (int d = 1; d <= 6; d++) strobe(8'(d));
        total++;
        if (fifo_full !== 1'b1 || ovf_err !== 1'b1 || m_tx_req !== 1'b1 || m_data_out !== 8'h02) begin
            bad++; $display("FAIL overflow: full=%b ovf=%b req=%b data=%h want 1/1/1/02", fifo_full, ovf_err, m_tx_req, m_data_out);
        end
`ifdef INC_ENGINE_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'd1) begin
            bad++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt);
        end
`endif
        done_pulse();
        strobe(8'h07);
        total++;
        if (fifo_full !== 1'b1 || ovf_err !== 1'b1) begin
            bad++; $display("FAIL push_pop_full: full=%b ovf=%b want 1/1", fifo_full, ovf_err);
        end
`ifdef INC_ENGINE_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'd1) begin
            bad++; $display("FAIL drop_cnt_pp: got %0d want 1", drop_cnt);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            wait_req(ok);
            total++;
            if (!ok || m_data_out !== drain[i]) begin
                bad++; $display("FAIL drain%0d: req=%b data=%h want 1/%h", i, m_tx_req, m_data_out, drain[i]);
            end
            done_pulse();
        end
        total++;
        if (fifo_empty !== 1'b1) begin
            bad++; $display("FAIL drain_empty: empty=%b want 1", fifo_empty);
        end
    endtask

    task automatic test_reset_midsend();
        button = 1'b1;
        sw_array_data = 8'h55;
        tick();
        button = 1'b0;
        strobe(8'h99);
        total++;
        if (m_tx_req !== 1'b1 || fifo_empty !== 1'b0 || ovf_err !== 1'b1) begin
            bad++; $display("FAIL pre_reset: req=%b empty=%b ovf=%b want 1/0/1", m_tx_req, fifo_empty, ovf_err);
        end
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (m_tx_req !== 1'b0 || fifo_empty !== 1'b1 || ovf_err !== 1'b0) begin
            bad++; $display("FAIL async_reset: req=%b empty=%b ovf=%b want 0/1/0", m_tx_req, fifo_empty, ovf_err);
        end
        total++;
        if (m_data_out !== 8'h00 || disp_data !== 8'h00) begin
            bad++; $display("FAIL async_reset_data: data=%h disp=%h want 00/00", m_data_out, disp_data);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (m_tx_req !== 1'b0 || fifo_empty !== 1'b1) begin
            bad++; $display("FAIL post_reset: req=%b empty=%b want 0/1", m_tx_req, fifo_empty);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_button();
        test_overflow();
        test_reset_midsend();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inc_engine.md
INC_ENGINE -- requirements
Module: inc_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data path width in bits (range 4..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter DELAY_COUNT, default 20, display-hold cycles before the operation (range 0..2^16-1).
REQ-004 SHALL have parameter STEP, default 1, increment/decrement amount (less than 2^DATA_WIDTH).
REQ-005 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port s_data, input, DATA_WIDTH bits, data from the slave port.
REQ-008 SHALL have port s_write_en_in, input, 1 bit, one-cycle strobe; s_data valid while high.
REQ-009 SHALL have port button, input, 1 bit, local-send request, level sampled.
REQ-010 SHALL have port sw_array_data, input, DATA_WIDTH bits, local switch data.
REQ-011 SHALL have port mode, input, 2 bits, operation select: 00 wrap-inc, 01 wrap-dec, 10 pass, 11 saturating inc.
REQ-012 SHALL have port m_tx_done, input, 1 bit, master transfer complete.
REQ-013 SHALL have port m_data_out, output, DATA_WIDTH bits, data to the master port.
REQ-014 SHALL have port m_tx_req, output, 1 bit, high while m_data_out is valid and awaiting m_tx_done.
REQ-015 SHALL have port disp_data, output, DATA_WIDTH bits, current working value for the display.
REQ-016 SHALL have ports fifo_full, fifo_empty and ovf_err, outputs, 1 bit each; ovf_err is sticky.

Function
REQ-017 SHALL implement states IDLE, HOLD and SEND.
REQ-018 SHALL push s_data on s_write_en_in when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-019 SHALL discard a push to a full FIFO with no same-cycle pop, and set ovf_err until reset.
REQ-020 IDLE with the FIFO non-empty SHALL pop the head into the working value, clear the delay counter and enter HOLD on the next edge.
REQ-021 IDLE with the FIFO empty and button high SHALL load sw_array_data into the working value and enter SEND, bypassing HOLD and the operation.
REQ-022 In IDLE a non-empty FIFO SHALL take priority over button.
REQ-023 HOLD SHALL last exactly DELAY_COUNT+1 cycles; on its last cycle it SHALL apply the mode operation to the working value and enter SEND.
REQ-024 mode SHALL be sampled only on the last HOLD cycle.
REQ-025 Wrap modes SHALL compute modulo 2^DATA_WIDTH; mode 11 SHALL clamp at all-ones; mode 10 SHALL leave the value unchanged.
REQ-026 On entry to SEND, m_data_out SHALL take the working value and m_tx_req SHALL go high; both SHALL hold stable until m_tx_done.
REQ-027 m_tx_done high in SEND SHALL drop m_tx_req on the next edge and return to IDLE; m_tx_done outside SEND SHALL be ignored.
REQ-028 disp_data SHALL equal the working value at all times and hold after SEND.
REQ-029 FIFO pushes SHALL continue in every state.

Reset
REQ-030 reset low SHALL immediately force state IDLE, FIFO empty, and the delay counter, working value, m_data_out, disp_data, m_tx_req and ovf_err to 0.
REQ-031 reset low mid-HOLD or mid-SEND SHALL abort the transfer with no further m_tx_req.

Configuration
REQ-032 With INC_ENGINE_DROP_CNT_EN defined, SHALL add output drop_cnt (8 bits, reset 0), counting discarded pushes and saturating at 255.
REQ-033 Without INC_ENGINE_DROP_CNT_EN, SHALL not have drop_cnt; all other behaviour is unchanged.

Verification
REQ-034 DW=8, DELAY_COUNT=3, mode=00: strobe s_data=0x41 -> disp_data=0x41 for 4 HOLD cycles, then m_data_out=0x42 with m_tx_req=1; m_tx_done -> m_tx_req=0 and back in IDLE.
REQ-035 mode=00 with 0xFF -> 0x00; mode=01 with 0x00 -> 0xFF; mode=11 with 0xFF -> 0xFF; mode=10 with 0x5A -> 0x5A.
REQ-036 FIFO empty, button=1, sw_array_data=0x3C -> m_data_out=0x3C in SEND with no HOLD; button and a strobe in the same IDLE cycle -> the strobed data is processed first.
REQ-037 FIFO_DEPTH=4, 6 strobes while blocked in SEND -> fifo_full=1, ovf_err=1, drop_cnt=1 if enabled; a push to a full FIFO coinciding with a pop is accepted.
REQ-038 reset low during SEND with m_tx_req=1 -> m_tx_req=0, fifo_empty=1 and ovf_err=0 immediately, without waiting for clk.
